packet_forwarder: RTL
=====================

Name: packet_forwarder

Overview:
Upstream neighbour of the reorder circular buffer. Accepts the packet filter IP's AXI-Stream input and assigns each packet a sequential reorder tag (mod CIRCULAR_BUFFER_SIZE). Picks a free filter core round-robin and streams the packet simultaneously to the circular buffer (with tag) and to the chosen core. Tracks outstanding tags by credit, so a tag is never reissued before the buffer retires it.

Parameters:
TAG_WIDTH, 6, width of reorder tag
CIRCULAR_BUFFER_SIZE, 50, number of tags/slots; tags run 0..SIZE-1
DATA_WIDTH, 64, AXIS data width
N_CORES, 4, number of parallel filter cores
MAX_TDATA_PER_PACKET, 256, max beats per packet

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_TDATA  in  DATA_WIDTH  ingress data
s_TLAST  in  1  ingress end of packet
s_TVALID  in  1  ingress valid
s_TREADY  out  1  ingress ready
buf_TDATA  out  DATA_WIDTH  to circular buffer
buf_tag  out  TAG_WIDTH  reorder tag of current packet
buf_TLAST  out  1  to buffer
buf_TVALID  out  1  to buffer
buf_TREADY  in  1  buffer ready
fwd_rdy  in  1  buffer can take a new packet
core_TDATA  out  DATA_WIDTH  shared data to cores
core_TLAST  out  1  shared last
core_TVALID  out  N_CORES  one-hot valid, selected core only
core_TREADY  in  N_CORES  per-core beat ready
core_idle  in  N_CORES  core can start a new packet
core_tag  out  TAG_WIDTH  tag given to the selected core
tag_free_valid  in  1  buffer retired one tag (output or reject)
alloc_valid  out  1  1-cycle pulse, new tag allocated
alloc_core  out  log2(N_CORES)  core bound to alloc tag
overflow_err  out  1  sticky, packet truncated
credit_err  out  1  sticky, free with zero outstanding

Behaviour:
- Reset: state IDLE; next_tag=0; outstanding=0; rr_ptr=0; beat_cnt=0; every output 0 (s_TREADY=0, all valids 0, sticky errors cleared). Reset mid-packet abandons the packet with no TLAST emitted. The downstream blocks are reset together with this block.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE: s_TREADY=0. Start condition: s_TVALID & fwd_rdy & |core_idle & outstanding<CIRCULAR_BUFFER_SIZE.
  - On start: latch sel = round-robin pick from core_idle, starting at rr_ptr.
  - Latch cur_tag=next_tag. Pulse alloc_valid with alloc_core=sel. Set rr_ptr=sel+1 mod N_CORES.
  - Go to STREAM. No data beat moves in the start cycle (1-cycle bubble).
- STREAM: datapath combinational, zero latency.
  - s_TREADY = buf_TREADY & core_TREADY[sel].
  - buf_TVALID = s_TVALID & core_TREADY[sel]. core_TVALID[sel] = s_TVALID & buf_TREADY. The beat transfers to both sinks or to neither.
  - buf_tag = core_tag = cur_tag.
  - Each transfer increments beat_cnt.
  - Transfer with s_TLAST: next_tag = (cur_tag==SIZE-1) ? 0 : cur_tag+1; beat_cnt=0; go to IDLE.
  - Transfer at beat_cnt==MAX-1 without s_TLAST: force buf_TLAST=core_TLAST=1; set overflow_err; advance tag as above; go to DRAIN.
- DRAIN: s_TREADY=1; all downstream valids 0. Discard beats until the s_TLAST transfer, then go to IDLE.
- Credits: outstanding += alloc_valid, -= tag_free_valid. A simultaneous alloc and free leaves outstanding unchanged. A free arriving at outstanding==0 is ignored and sets credit_err.
- A fwd_rdy deassertion during STREAM does not stall the packet in flight; it only gates the next start.
- Widths: beat_cnt is clog2(MAX_TDATA_PER_PACKET) bits. Tag compare is against SIZE-1, not 2^TAG_WIDTH-1.

Decomposition:
- Package pf_pkg holds: TAG_WIDTH, CIRCULAR_BUFFER_SIZE, MAX_TDATA_PER_PACKET defaults, the fwd_state_t enum (IDLE/STREAM/DRAIN), and a tag_inc function that implements the wrap.
- One sub-module, rr_arbiter (N_CORES requests, pointer in, one-hot grant plus index out, combinational).

Test Plan:
- 3 packets of 4 beats, all cores idle, all readys high -> tags 0,1,2 on cores 0,1,2; alloc_valid pulses 3 times; buf_TLAST on beats 4, 8, 12; outstanding=3.
- 50 packets with no tag_free_valid -> 51st packet held (s_TREADY=0). One free pulse -> 51st starts with tag 0 (wrap).
- core_TREADY[sel] toggled 1,0,1 mid-packet -> buf_TVALID drops in the same cycle; no beat duplicated or lost; sequence D0..D3 intact at both sinks.
- 300-beat packet, MAX=256 -> forced TLAST on beat 256; overflow_err=1; beats 257-300 dropped; next packet gets the next tag.
- alloc_valid and tag_free_valid in the same cycle at outstanding=5 -> stays 5. Free at 0 -> credit_err=1, outstanding stays 0.
- rst asserted on beat 2 of a packet -> next cycle all outputs 0, state IDLE; next packet gets tag 0, core 0.

Source files
------------

// File: rtl/packet_forwarder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pf_pkg
//  Purpose  : Shared defaults, FSM state type and reorder-tag wrap helper
//             for the packet forwarder.
//  Revision : 1.0  initial release
// ============================================================================
package pf_pkg;

  localparam int TAG_WIDTH            = 6;
  localparam int CIRCULAR_BUFFER_SIZE = 50;
  localparam int MAX_TDATA_PER_PACKET = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } fwd_state_t;

  // Tags run 0..size-1; wrap against the buffer size, not the tag width.
  function automatic int unsigned tag_inc(input int unsigned tag, input int unsigned size);
    return (tag == size - 1) ? 0 : tag + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_forwarder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick among N requesters, searching
//             upward from ptr_i with wrap. Returns one-hot grant and index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // First requester at or after the pointer wins.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/packet_forwarder.sv
`default_nettype none
// ============================================================================
//  Module   : packet_forwarder
//  Purpose  : Tags each ingress AXI-Stream packet with a sequential reorder
//             tag, picks an idle filter core round-robin, and streams the
//             packet to the circular buffer and that core in lockstep.
//             Outstanding tags are credit-tracked so none is reissued early.
//  Revision : 1.0  initial release
// ============================================================================
module packet_forwarder #(
  parameter  int TAG_WIDTH            = pf_pkg::TAG_WIDTH,
  parameter  int CIRCULAR_BUFFER_SIZE = pf_pkg::CIRCULAR_BUFFER_SIZE,
  parameter  int DATA_WIDTH           = 64,
  parameter  int N_CORES              = 4,
  parameter  int MAX_TDATA_PER_PACKET = pf_pkg::MAX_TDATA_PER_PACKET,
  localparam int CORE_W               = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_TDATA,
  input  logic                  s_TLAST,
  input  logic                  s_TVALID,
  output logic                  s_TREADY,
  output logic [DATA_WIDTH-1:0] buf_TDATA,
  output logic [TAG_WIDTH-1:0]  buf_tag,
  output logic                  buf_TLAST,
  output logic                  buf_TVALID,
  input  logic                  buf_TREADY,
  input  logic                  fwd_rdy,
  output logic [DATA_WIDTH-1:0] core_TDATA,
  output logic                  core_TLAST,
  output logic [N_CORES-1:0]    core_TVALID,
  input  logic [N_CORES-1:0]    core_TREADY,
  input  logic [N_CORES-1:0]    core_idle,
  output logic [TAG_WIDTH-1:0]  core_tag,
  input  logic                  tag_free_valid,
  output logic                  alloc_valid,
  output logic [CORE_W-1:0]     alloc_core,
  output logic                  overflow_err,
  output logic                  credit_err
);

  import pf_pkg::*;

  localparam int c_BEAT_W = (MAX_TDATA_PER_PACKET > 1) ? $clog2(MAX_TDATA_PER_PACKET) : 1;
  localparam int c_OUT_W  = $clog2(CIRCULAR_BUFFER_SIZE + 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(MAX_TDATA_PER_PACKET - 1);
  localparam logic [c_OUT_W-1:0]  c_SIZE      = c_OUT_W'(CIRCULAR_BUFFER_SIZE);
  localparam logic [CORE_W-1:0]   c_CORE_LAST = CORE_W'(N_CORES - 1);

  fwd_state_t            state_q, state_d;
  logic [TAG_WIDTH-1:0]  next_tag_q, next_tag_d;
  logic [TAG_WIDTH-1:0]  cur_tag_q, cur_tag_d;
  logic [c_OUT_W-1:0]    outstanding_q, outstanding_d;
  logic [CORE_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CORE_W-1:0]     sel_q, sel_d;
  logic [N_CORES-1:0]    sel_oh_q, sel_oh_d;
  logic [c_BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  overflow_err_q, overflow_err_d;
  logic                  credit_err_q, credit_err_d;

  logic [N_CORES-1:0]    w_gnt_oh;
  logic [CORE_W-1:0]     w_gnt_idx;
  logic                  w_gnt_valid;
  logic                  w_start;
  logic                  w_sel_rdy;
  logic                  w_xfer;
  logic                  w_at_max;
  logic [TAG_WIDTH-1:0]  w_tag_adv;

  rr_arbiter #(.N(N_CORES)) u_arb (
    .req_i   (core_idle),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (w_gnt_oh),
    .idx_o   (w_gnt_idx),
    .valid_o (w_gnt_valid)
  );

  // A start is blocked while rst is high so nothing is allocated in the reset cycle.
  assign w_start   = (state_q == IDLE) && !rst && s_TVALID && fwd_rdy && w_gnt_valid
                     && (outstanding_q < c_SIZE);
  assign w_sel_rdy = |(core_TREADY & sel_oh_q);
  assign w_xfer    = (state_q == STREAM) && s_TVALID && buf_TREADY && w_sel_rdy;
  assign w_at_max  = (beat_cnt_q == c_BEAT_LAST);
  assign w_tag_adv = TAG_WIDTH'(tag_inc(32'(cur_tag_q), CIRCULAR_BUFFER_SIZE));

  assign overflow_err = overflow_err_q;
  assign credit_err   = credit_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: packet ends on TLAST, or truncates into DRAIN at the beat limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (w_start) state_d = STREAM;
      STREAM: if (w_xfer) begin
                if (s_TLAST)       state_d = IDLE;
                else if (w_at_max) state_d = DRAIN;
              end
      DRAIN:  if (s_TVALID && s_TLAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: zero-latency datapath in STREAM, beat sink in DRAIN, quiet otherwise.
  always_comb begin
    s_TREADY    = 1'b0;
    buf_TDATA   = '0;
    buf_tag     = '0;
    buf_TLAST   = 1'b0;
    buf_TVALID  = 1'b0;
    core_TDATA  = '0;
    core_TLAST  = 1'b0;
    core_TVALID = '0;
    core_tag    = '0;
    alloc_valid = w_start;
    alloc_core  = w_start ? w_gnt_idx : '0;
    case (state_q)
      STREAM: begin
        s_TREADY    = buf_TREADY && w_sel_rdy;
        buf_TVALID  = s_TVALID && w_sel_rdy;
        core_TVALID = sel_oh_q & {N_CORES{s_TVALID && buf_TREADY}};
        buf_TDATA   = s_TDATA;
        core_TDATA  = s_TDATA;
        buf_TLAST   = s_TLAST || w_at_max;
        core_TLAST  = s_TLAST || w_at_max;
        buf_tag     = cur_tag_q;
        core_tag    = cur_tag_q;
      end
      DRAIN: s_TREADY = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: tag/core latch on start, beat counting, credits, sticky errors.
  always_comb begin
    next_tag_d     = next_tag_q;
    cur_tag_d      = cur_tag_q;
    outstanding_d  = outstanding_q;
    rr_ptr_d       = rr_ptr_q;
    sel_d          = sel_q;
    sel_oh_d       = sel_oh_q;
    beat_cnt_d     = beat_cnt_q;
    overflow_err_d = overflow_err_q;
    credit_err_d   = credit_err_q;

    if (w_start) begin
      cur_tag_d  = next_tag_q;
      sel_d      = w_gnt_idx;
      sel_oh_d   = w_gnt_oh;
      rr_ptr_d   = (w_gnt_idx == c_CORE_LAST) ? '0 : w_gnt_idx + 1'b1;
      beat_cnt_d = '0;
    end

    if (w_xfer) begin
      if (s_TLAST || w_at_max) begin
        next_tag_d = w_tag_adv;
        beat_cnt_d = '0;
        if (!s_TLAST) overflow_err_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    // Simultaneous alloc and free cancel; a free with nothing outstanding is an error.
    case ({w_start, tag_free_valid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   if (outstanding_q == '0) credit_err_d = 1'b1;
               else                     outstanding_d = outstanding_q - 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag_q     <= '0;
      cur_tag_q      <= '0;
      outstanding_q  <= '0;
      rr_ptr_q       <= '0;
      sel_q          <= '0;
      sel_oh_q       <= '0;
      beat_cnt_q     <= '0;
      overflow_err_q <= 1'b0;
      credit_err_q   <= 1'b0;
    end else begin
      next_tag_q     <= next_tag_d;
      cur_tag_q      <= cur_tag_d;
      outstanding_q  <= outstanding_d;
      rr_ptr_q       <= rr_ptr_d;
      sel_q          <= sel_d;
      sel_oh_q       <= sel_oh_d;
      beat_cnt_q     <= beat_cnt_d;
      overflow_err_q <= overflow_err_d;
      credit_err_q   <= credit_err_d;
    end
  end

endmodule
`default_nettype wire
